// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC accumulate stage.
// Helpers work on MAX_W-bit vectors; callers sign/zero-extend into them and
// cast results back down to their own widths.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Widest accumulator any supported configuration needs (N=32 -> 67 bits).
    localparam int MAX_W = 128;

    typedef struct packed {
        logic             sign;
        logic [MAX_W-1:0] mag;
        logic             sat;
    } sm_sat_t;

    // Accumulator width: full-precision product plus headroom for the sum.
    function automatic int acc_w(input int n, input int terms);
        return 2 * n + $clog2(terms);
    endfunction

    // Beat counter width: must hold values 0..terms.
    function automatic int cnt_w(input int terms);
        return $clog2(terms + 1);
    endfunction

    // Sign-magnitude to two's complement; -0 maps to 0.
    function automatic logic [MAX_W-1:0] sm_to_tc(input logic sign, input logic [MAX_W-1:0] mag);
        return sign ? (~mag + MAX_W'(1)) : mag;
    endfunction

    // Two's complement to sign-magnitude, magnitude shifted right by q
    // (truncating toward zero) and clamped to n-1 bits. Zero is always +0.
    function automatic sm_sat_t tc_to_sm_sat(input logic [MAX_W-1:0] v, input int q, input int n);
        sm_sat_t          r;
        logic [MAX_W-1:0] abs_v;
        logic [MAX_W-1:0] shifted;
        logic [MAX_W-1:0] max_mag;
        abs_v   = v[MAX_W-1] ? (~v + MAX_W'(1)) : v;
        shifted = abs_v >> q;
        max_mag = (MAX_W'(1) << (n - 1)) - MAX_W'(1);
        r.sat   = (shifted > max_mag);
        r.mag   = r.sat ? max_mag : shifted;
        r.sign  = v[MAX_W-1] && (r.mag != '0);
        return r;
    endfunction

endpackage

// File: rtl/mac_out_format.sv
// Combinational rescale of the accumulator to an N-bit Q-format
// sign-magnitude result with saturation and negative-zero cleanup.
module mac_out_format
    import mac_pkg::*;
#(
    parameter int Q     = 24,
    parameter int N     = 32,
    parameter int ACC_W = 67
) (
    input  logic [ACC_W-1:0] i_acc,
    output logic [N-1:0]     o_result,
    output logic             o_sat
);

    sm_sat_t fmt;

    // Sign-extend into the helper width, then rescale and clamp.
    always_comb begin
        fmt      = tc_to_sm_sat({{(MAX_W-ACC_W){i_acc[ACC_W-1]}}, i_acc}, Q, N);
        o_result = {fmt.sign, (N-1)'(fmt.mag)};
        o_sat    = fmt.sat;
    end

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates TERMS full-precision sign-magnitude products and presents one
// saturated N-bit Q-format sign-magnitude result over valid/ready.
// Optional build macro: MAC_BIAS_EN adds i_bias, folded in with the first term.
//
// state | meaning
// IDLE  | waiting for first product of a batch, o_ready=1
// ACCUM | summing remaining products, o_ready=1
// DONE  | result held, o_valid=1, o_ready=0 until i_ready
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int Q     = 24,
    parameter int N     = 32,
    parameter int TERMS = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [2*N-1:0] i_product,
    input  logic           i_ovr,
    input  logic           i_valid,
`ifdef MAC_BIAS_EN
    input  logic [N-1:0]   i_bias,
`endif
    output logic           o_ready,
    output logic [N-1:0]   o_result,
    output logic           o_ovr,
    output logic           o_valid,
    input  logic           i_ready
);

`ifdef MAC_BIAS_EN
    // One extra bit so TERMS products plus a bias can never wrap.
    localparam int BIAS_BITS = 1;
`else
    localparam int BIAS_BITS = 0;
`endif
    localparam int ACC_W = acc_w(N, TERMS) + BIAS_BITS;
    localparam int CNT_W = cnt_w(TERMS);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovr_s_q, ovr_s_d;
    logic [N-1:0]       result_q, result_d;
    logic               ovr_q, ovr_d;

    logic [ACC_W-1:0]   term;
    logic [ACC_W-1:0]   first_term;
    logic [ACC_W-1:0]   acc_sum;
    logic [N-1:0]       fmt_result;
    logic               fmt_sat;
    logic               accept;

    assign o_ready  = (state_q != DONE);
    assign o_valid  = (state_q == DONE);
    assign o_result = result_q;
    assign o_ovr    = ovr_q;
    assign accept   = i_valid && o_ready;

    // Signed contribution of the incoming product (and bias on the first beat).
    always_comb begin
        term = ACC_W'(sm_to_tc(i_product[2*N-1],
                               {{(MAX_W-2*N+1){1'b0}}, i_product[2*N-2:0]}));
`ifdef MAC_BIAS_EN
        first_term = term + ACC_W'(sm_to_tc(i_bias[N-1],
                               {{(MAX_W-N+1){1'b0}}, i_bias[N-2:0]} << Q));
`else
        first_term = term;
`endif
        acc_sum = acc_q + term;
    end

    // The final accept formats the sum including the last product.
    mac_out_format #(
        .Q     (Q),
        .N     (N),
        .ACC_W (ACC_W)
    ) u_out_format (
        .i_acc    (acc_sum),
        .o_result (fmt_result),
        .o_sat    (fmt_sat)
    );

    // Next-state and datapath updates for the batch sequencer.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovr_s_d  = ovr_s_q;
        result_d = result_q;
        ovr_d    = ovr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = first_term;
                    cnt_d   = CNT_W'(1);
                    ovr_s_d = i_ovr;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d   = acc_sum;
                    cnt_d   = cnt_q + CNT_W'(1);
                    ovr_s_d = ovr_s_q | i_ovr;
                    if (cnt_q == CNT_W'(TERMS - 1)) begin
                        result_d = fmt_result;
                        ovr_d    = fmt_sat | ovr_s_q | i_ovr;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (i_ready) begin
                    acc_d    = '0;
                    cnt_d    = '0;
                    ovr_s_d  = 1'b0;
                    result_d = '0;
                    ovr_d    = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovr_s_q  <= 1'b0;
            result_q <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovr_s_q  <= ovr_s_d;
            result_q <= result_d;
            ovr_q    <= ovr_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator at N=8, Q=4, TERMS=4 (1.0 product = 0x0100).
module tb_mac_accumulator;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [15:0] i_product;
    logic        i_ovr;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  o_result;
    logic        o_ovr;
    logic        o_valid;
    logic        i_ready;
`ifdef MAC_BIAS_EN
    logic [7:0]  i_bias;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    mac_accumulator #(.Q(4), .N(8), .TERMS(4)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_product (i_product),
        .i_ovr     (i_ovr),
        .i_valid   (i_valid),
`ifdef MAC_BIAS_EN
        .i_bias    (i_bias),
`endif
        .o_ready   (o_ready),
        .o_result  (o_result),
        .o_ovr     (o_ovr),
        .o_valid   (o_valid),
        .i_ready   (i_ready)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Feed four products, check latency/result, optionally complete the handshake.
    task automatic run_batch(input string tag,
                             input logic [15:0] p0, input logic [15:0] p1,
                             input logic [15:0] p2, input logic [15:0] p3,
                             input logic [3:0] ovr_mask,
                             input logic [7:0] exp_res, input logic exp_ovr,
                             input bit do_hs);
        logic [15:0] p [4];
        int          waited;
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_product = p[i];
            i_ovr     = ovr_mask[i];
            i_valid   = 1'b1;
            if (i == 3) chk({tag, ".valid_early"}, {31'd0, o_valid}, 32'd0);
            step();
        end
        i_valid   = 1'b0;
        i_ovr     = 1'b0;
        i_product = '0;
        chk({tag, ".latency"}, {31'd0, o_valid}, 32'd1);
        waited = 0;
        while (!o_valid && waited < 8) begin
            step();
            waited++;
        end
        chk({tag, ".result"}, {24'd0, o_result}, {24'd0, exp_res});
        chk({tag, ".ovr"}, {31'd0, o_ovr}, {31'd0, exp_ovr});
        if (do_hs) begin
            i_ready = 1'b1;
            step();
            i_ready = 1'b0;
            chk({tag, ".valid_drop"}, {31'd0, o_valid}, 32'd0);
        end
    endtask

    initial begin
        i_rst     = 1'b1;
        i_product = '0;
        i_ovr     = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
`ifdef MAC_BIAS_EN
        i_bias    = '0;
`endif
        step();
        step();
        chk("rst.valid",  {31'd0, o_valid}, 32'd0);
        chk("rst.ready",  {31'd0, o_ready}, 32'd1);
        chk("rst.result", {24'd0, o_result}, 32'd0);
        chk("rst.ovr",    {31'd0, o_ovr}, 32'd0);
        i_rst = 1'b0;
        step();

        run_batch("ones",    16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'b0000, 8'h40, 1'b0, 1);
        run_batch("mixed",   16'h0100, 16'h8100, 16'h0100, 16'h0100, 4'b0000, 8'h20, 1'b0, 1);
        run_batch("neg",     16'h8100, 16'h8100, 16'h8100, 16'h8100, 4'b0000, 8'hC0, 1'b0, 1);
        run_batch("sat_pos", 16'h0400, 16'h0400, 16'h0400, 16'h0400, 4'b0000, 8'h7F, 1'b1, 1);
        run_batch("sat_neg", 16'h8400, 16'h8400, 16'h8400, 16'h8400, 4'b0000, 8'hFF, 1'b1, 1);
        run_batch("in_ovr",  16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'b0100, 8'h40, 1'b1, 1);
        run_batch("trunc",   16'h0008, 16'h0008, 16'h0008, 16'h0008, 4'b0000, 8'h02, 1'b0, 1);
        run_batch("trunc_n", 16'h8008, 16'h8008, 16'h8008, 16'h8008, 4'b0000, 8'h82, 1'b0, 1);
        run_batch("trunc_n2",16'h8005, 16'h8005, 16'h8005, 16'h8005, 4'b0000, 8'h81, 1'b0, 1);
        run_batch("negzero", 16'h0001, 16'h8001, 16'h0001, 16'h8001, 4'b0000, 8'h00, 1'b0, 1);

        // Backpressure: result held, extra products refused.
        run_batch("bp", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'b0000, 8'h40, 1'b0, 0);
        i_product = 16'h0700;
        i_valid   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp.hold_result", {24'd0, o_result}, 32'h40);
            chk("bp.hold_ready",  {31'd0, o_ready}, 32'd0);
            chk("bp.hold_valid",  {31'd0, o_valid}, 32'd1);
        end
        i_valid   = 1'b0;
        i_product = '0;
        i_ready   = 1'b1;
        step();
        i_ready   = 1'b0;
        chk("bp.release", {31'd0, o_valid}, 32'd0);
        run_batch("bp_after", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'b0000, 8'h40, 1'b0, 1);

        // Mid-batch reset, asserted alongside a valid product.
        i_product = 16'h0400;
        i_valid   = 1'b1;
        step();
        step();
        i_rst = 1'b1;
        step();
        i_rst     = 1'b0;
        i_valid   = 1'b0;
        i_product = '0;
        chk("mrst.ready",  {31'd0, o_ready}, 32'd1);
        chk("mrst.valid",  {31'd0, o_valid}, 32'd0);
        chk("mrst.result", {24'd0, o_result}, 32'd0);
        run_batch("mrst_after", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'b0000, 8'h40, 1'b0, 1);

`ifdef MAC_BIAS_EN
        i_bias = 8'h90;
        run_batch("bias", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'b0000, 8'h30, 1'b0, 1);
        i_bias = 8'h00;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
